// File: rtl/rlim_pkg.sv
// Shared types for the rlim4 speed monitor: FSM states, command encoding
// and the command priority decode (stop > high > low, idle means stop).
package rlim_pkg;

   typedef enum logic [1:0] {
      HALT = 2'd0,
      SLEW = 2'd1,
      LOCK = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CMD_STOP = 2'd0,
      CMD_LOW  = 2'd1,
      CMD_HIGH = 2'd2
   } cmd_e;

   // Priority decode of the raw speed command lines
   function automatic cmd_e decode_cmd(input logic stopped,
                                       input logic hs,
                                       input logic ls);
      cmd_e c;
      c = CMD_STOP;
      if (stopped)  c = CMD_STOP;
      else if (hs)  c = CMD_HIGH;
      else if (ls)  c = CMD_LOW;
      return c;
   endfunction

endpackage

// File: rtl/rlim_tach_window.sv
// Fixed-length measurement window: rising-edge detect on the pulse train,
// free-running window counter and saturating edge counter.
// Ports:
//   i_clk, i_reset  clock, async active-high reset
//   i_pulse         pulse train (synchronous to i_clk)
//   o_end_c         high on the last cycle of each window (combinational)
//   o_value_c       saturated edge count including this cycle's edge (combinational)
module rlim_tach_window #(
   parameter int unsigned WINDOW = 1024,
   parameter int unsigned CW     = 10
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_pulse,
   output logic          o_end_c,
   output logic [CW-1:0] o_value_c
);

   localparam int unsigned     WW     = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [WW-1:0]   W_LAST = WW'(WINDOW - 1);
   localparam logic [CW-1:0]   E_MAX  = '1;

   logic          r_pulse_q;
   logic [WW-1:0] r_wcnt;
   logic [CW-1:0] r_ecnt;
   logic          w_edge;
   logic          w_end;
   logic [CW-1:0] w_ecnt_inc;

   assign w_edge     = i_pulse & ~r_pulse_q;
   assign w_end      = (r_wcnt == W_LAST);
   assign w_ecnt_inc = (w_edge && (r_ecnt != E_MAX)) ? (r_ecnt + CW'(1)) : r_ecnt;

   // Window/edge counters; the edge seen on the last cycle is folded into the reported value
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_pulse_q <= 1'b0;
         r_wcnt    <= '0;
         r_ecnt    <= '0;
      end else begin
         r_pulse_q <= i_pulse;
         r_wcnt    <= w_end ? '0 : (r_wcnt + WW'(1));
         r_ecnt    <= w_end ? '0 : w_ecnt_inc;
      end
   end

   assign o_end_c   = w_end;
   assign o_value_c = w_ecnt_inc;

endmodule

// File: rtl/rlim_tach.sv
// Speed monitor for the rlim4 rate limiter output. Counts pulse edges per
// window, compares against the commanded speed and tracks HALT/SLEW/LOCK.
// A lock lost without a command change raises a sticky fault.
// Ports:
//   i_clk, i_reset        clock, async active-high reset
//   i_pulse               rlim4 o_out pulse train
//   i_hs, i_ls, i_stopped speed command lines
//   i_clr_fault           single-cycle fault clear
//   o_count, o_valid      last window's edge count and its update strobe
//   o_halted, o_at_speed  registered state decodes (HALT, LOCK)
//   o_fault               sticky loss-of-lock flag
module rlim_tach
   import rlim_pkg::*;
#(
   parameter int unsigned WINDOW    = 1024,
   parameter int unsigned CW        = 10,
   parameter int unsigned LOWCOUNT  = 64,
   parameter int unsigned HIGHCOUNT = 128,
   parameter int unsigned TOL       = 4,
   parameter int unsigned STOPCOUNT = 2,
   parameter int unsigned SETTLE    = 3
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_pulse,
   input  logic          i_hs,
   input  logic          i_ls,
   input  logic          i_stopped,
   input  logic          i_clr_fault,
   output logic [CW-1:0] o_count,
   output logic          o_valid,
   output logic          o_halted,
   output logic          o_at_speed,
   output logic          o_fault
);

   localparam logic [CW:0]     LOW_T      = (CW+1)'(LOWCOUNT);
   localparam logic [CW:0]     HIGH_T     = (CW+1)'(HIGHCOUNT);
   localparam logic [CW:0]     TOL_T      = (CW+1)'(TOL);
   localparam logic [CW-1:0]   STOP_T     = CW'(STOPCOUNT);
   localparam int unsigned     SW         = $clog2(SETTLE + 1);
   localparam logic [SW-1:0]   SETTLE_MAX = SW'(SETTLE);
   localparam logic [SW-1:0]   SETTLE_PRE = SW'(SETTLE - 1);

   logic          w_end;
   logic [CW-1:0] w_value;
   cmd_e          w_cmd;
   logic          w_cmd_chg;
   logic [CW:0]   w_value_x;
   logic [CW:0]   w_target;
   logic [CW:0]   w_diff;
   logic          w_match;
   logic          w_settle_hit;
   logic          w_fault_set;

   state_e        r_state;
   cmd_e          r_cmd_q;
   logic [SW-1:0] r_settle;
   logic [CW-1:0] r_count;
   logic          r_valid;
   logic          r_halted;
   logic          r_at_speed;
   logic          r_fault;

   rlim_tach_window #(
      .WINDOW (WINDOW),
      .CW     (CW)
   ) u_window (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_pulse   (i_pulse),
      .o_end_c   (w_end),
      .o_value_c (w_value)
   );

   assign w_cmd     = decode_cmd(i_stopped, i_hs, i_ls);
   assign w_cmd_chg = (w_cmd != r_cmd_q);

   // Window value vs. commanded target; difference taken one bit wider so it cannot wrap
   always_comb begin
      w_value_x = {1'b0, w_value};
      w_target  = '0;
      w_diff    = '0;
      w_match   = 1'b0;
      case (w_cmd)
         CMD_LOW:  w_target = LOW_T;
         CMD_HIGH: w_target = HIGH_T;
         default:  w_target = '0;
      endcase
      w_diff  = (w_value_x >= w_target) ? (w_value_x - w_target) : (w_target - w_value_x);
      w_match = (w_cmd == CMD_STOP) ? (w_value <= STOP_T) : (w_diff <= TOL_T);
   end

   // This window completes the required run of matching windows
   assign w_settle_hit = w_match && (r_settle == SETTLE_PRE);
   // Lock lost at window end; a simultaneous command change takes precedence
   assign w_fault_set  = (r_state == LOCK) && w_end && !w_cmd_chg && !w_match;

   // State, settle counter, fault and registered outputs
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= HALT;
         r_cmd_q    <= CMD_STOP;
         r_settle   <= '0;
         r_count    <= '0;
         r_valid    <= 1'b0;
         r_halted   <= 1'b1;
         r_at_speed <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         r_cmd_q    <= w_cmd;
         r_valid    <= w_end;
         r_halted   <= (r_state == HALT);
         r_at_speed <= (r_state == LOCK);
         if (w_end) r_count <= w_value;

         if (w_fault_set)      r_fault <= 1'b1;
         else if (i_clr_fault) r_fault <= 1'b0;

         if (w_cmd_chg) begin
            r_settle <= '0;
         end else if (w_end) begin
            if (!w_match)                    r_settle <= '0;
            else if (r_settle != SETTLE_MAX) r_settle <= r_settle + SW'(1);
         end

         case (r_state)
            HALT: begin
               if (w_cmd_chg) begin
                  if (w_cmd != CMD_STOP) r_state <= SLEW;
               end else if (w_end && (w_value > STOP_T)) begin
                  r_state <= SLEW;
               end
            end
            SLEW: begin
               if (!w_cmd_chg && w_end && w_settle_hit)
                  r_state <= (w_cmd == CMD_STOP) ? HALT : LOCK;
            end
            LOCK: begin
               if (w_cmd_chg || (w_end && !w_match)) r_state <= SLEW;
            end
            default: r_state <= HALT;
         endcase
      end
   end

   assign o_count    = r_count;
   assign o_valid    = r_valid;
   assign o_halted   = r_halted;
   assign o_at_speed = r_at_speed;
   assign o_fault    = r_fault;

endmodule

// File: tb/tb_rlim_tach.sv
// Scoreboard bench for rlim_tach: randomized pulse trains and commands,
// expected behaviour from an abstract window/command model.
module tb_rlim_tach;

   localparam int W   = 1024;
   localparam int BIG = 1 << 30;
   localparam int M_HALT = 0;
   localparam int M_SLEW = 1;
   localparam int M_LOCK = 2;

   logic clk = 1'b0;
   logic rst, pulse, hs, ls, st, clr;
   logic [9:0] count;
   logic       valid, halted, at_speed, fault;
   logic [7:0] count8;
   logic       valid8, halted8, at8, fault8;

   always #5 clk = ~clk;

   rlim_tach dut (
      .i_clk(clk), .i_reset(rst), .i_pulse(pulse), .i_hs(hs), .i_ls(ls),
      .i_stopped(st), .i_clr_fault(clr), .o_count(count), .o_valid(valid),
      .o_halted(halted), .o_at_speed(at_speed), .o_fault(fault)
   );

   rlim_tach #(.CW(8)) dut8 (
      .i_clk(clk), .i_reset(rst), .i_pulse(pulse), .i_hs(hs), .i_ls(ls),
      .i_stopped(st), .i_clr_fault(clr), .o_count(count8), .o_valid(valid8),
      .o_halted(halted8), .o_at_speed(at8), .o_fault(fault8)
   );

   typedef struct { bit valid; bit halted; bit at; bit fault; } flags_t;
   typedef struct { int c10; int c8; } cnt_t;

   flags_t fq[$];
   cnt_t   cq[$];
   int tests = 0;
   int fails = 0;

   // model state
   int m_prev, m_wpos, m_raw, m_cmdq, m_state, m_run;
   bit m_fault;

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_init();
      m_prev = 0; m_wpos = 0; m_raw = 0; m_cmdq = 0;
      m_state = M_HALT; m_run = 0; m_fault = 0;
   endfunction

   // Drive one cycle of inputs and predict the effect of the coming clock edge
   task automatic step(input bit p, input bit h, input bit l, input bit s, input bit c);
      int edge_now, raw, v10, v8, cmd, tgt, d;
      bit chg, wend, match, fset;
      flags_t f;
      pulse = p; hs = h; ls = l; st = s; clr = c;
      edge_now = (p && m_prev == 0) ? 1 : 0;
      m_prev   = p;
      raw  = m_raw + edge_now;
      v10  = (raw > 1023) ? 1023 : raw;
      v8   = (raw > 255) ? 255 : raw;
      cmd  = s ? 0 : (h ? 2 : (l ? 1 : 0));
      chg  = (cmd != m_cmdq);
      m_cmdq = cmd;
      wend = (m_wpos == W - 1);
      if (cmd == 0) match = (v10 <= 2);
      else begin
         tgt = (cmd == 2) ? 128 : 64;
         d = (v10 > tgt) ? v10 - tgt : tgt - v10;
         match = (d <= 4);
      end
      f.valid  = wend;
      f.halted = (m_state == M_HALT);
      f.at     = (m_state == M_LOCK);
      fset = 0;
      if (chg) begin
         m_run = 0;
         if (m_state == M_LOCK || (m_state == M_HALT && cmd != 0)) m_state = M_SLEW;
      end else if (wend) begin
         m_run = match ? m_run + 1 : 0;
         if (m_state == M_HALT) begin
            if (v10 > 2) m_state = M_SLEW;
         end else if (m_state == M_SLEW) begin
            if (match && m_run == 3) m_state = (cmd == 0) ? M_HALT : M_LOCK;
         end else begin
            if (!match) begin m_state = M_SLEW; fset = 1; end
         end
      end
      if (fset) m_fault = 1;
      else if (c) m_fault = 0;
      f.fault = m_fault;
      fq.push_back(f);
      if (wend) cq.push_back('{v10, v8});
      m_raw  = wend ? 0 : raw;
      m_wpos = (m_wpos + 1) % W;
   endtask

   task automatic cyc(input bit p, input bit h, input bit l, input bit s, input bit c);
      @(posedge clk);
      #2;
      step(p, h, l, s, c);
   endtask

   task automatic run(input int n, input int period, input int duty, input int ph,
                      input bit h, input bit l, input bit s,
                      input int stop_after, input int clr_at);
      for (int c = 0; c < n; c++) begin
         bit p;
         p = (period > 0) && (c < stop_after) && (((c + ph) % period) < duty);
         cyc(p, h, l, s, c == clr_at);
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_count"},  count,    0);
      chk({tag, "_valid"},  valid,    0);
      chk({tag, "_halted"}, halted,   1);
      chk({tag, "_at"},     at_speed, 0);
      chk({tag, "_fault"},  fault,    0);
   endtask

   task automatic release_reset(input bit h, input bit l, input bit s);
      @(posedge clk);
      #2;
      rst = 1'b0;
      model_init();
      step(1'b0, h, l, s, 1'b0);
   endtask

   // Monitor: per-cycle flag scoreboard, counts popped whenever o_valid is seen
   initial begin
      flags_t f;
      cnt_t   e;
      forever begin
         @(posedge clk);
         #1;
         if (fq.size() > 0) begin
            f = fq.pop_front();
            chk("valid",    valid,    f.valid);
            chk("halted",   halted,   f.halted);
            chk("at_speed", at_speed, f.at);
            chk("fault",    fault,    f.fault);
            chk("valid8",   valid8,   f.valid);
            chk("halted8",  halted8,  f.halted);
            chk("at8",      at8,      f.at);
            chk("fault8",   fault8,   f.fault);
            if (valid === 1'b1) begin
               if (cq.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL count_unexpected: o_valid with no expected window, count=%0d", count);
               end else begin
                  e = cq.pop_front();
                  chk("count",  count,  e.c10);
                  chk("count8", count8, e.c8);
               end
            end
         end
      end
   end

   initial begin
      int ph, d, dh, dens, k;
      bit rh, rl, rs, rc;
      rst = 1'b1; pulse = 0; hs = 0; ls = 0; st = 1; clr = 0;
      model_init();
      repeat (3) @(posedge clk);
      #3;
      check_reset_values("reset");

      // stopped, no pulses, 4 windows
      release_reset(1'b0, 1'b0, 1'b1);
      run(4 * W - 1, 0, 0, 0, 0, 0, 1, BIG, -1);
      chk("stop_halted", halted, 1);
      chk("stop_at", at_speed, 0);

      // low speed, period 16
      ph = $urandom_range(0, 15);
      d  = $urandom_range(1, 8);
      run(3, 16, d, ph, 0, 1, 0, BIG, -1);
      chk("low_left_halt", halted, 0);
      run(4 * W - 3, 16, d, ph + 3, 0, 1, 0, BIG, -1);
      chk("low_lock", at_speed, 1);
      chk("low_nofault", fault, 0);

      // period 14 while locked low: lock lost, sticky fault
      ph = $urandom_range(0, 13);
      d  = $urandom_range(1, 7);
      run(2 * W, 14, d, ph, 0, 1, 0, BIG, -1);
      chk("p14_fault", fault, 1);
      chk("p14_unlocked", at_speed, 0);
      run(W, 14, d, ph + 2 * W, 0, 1, 0, BIG, 500);
      chk("clr_fault", fault, 0);

      // relock low
      ph = $urandom_range(0, 15);
      run(4 * W, 16, d, ph, 0, 1, 0, BIG, -1);
      chk("relock_low", at_speed, 1);

      // switch to high speed, period 8
      ph = $urandom_range(0, 7);
      dh = $urandom_range(1, 4);
      run(3, 8, dh, ph, 1, 0, 0, BIG, -1);
      chk("hs_slew", at_speed, 0);
      chk("hs_nofault", fault, 0);
      run(4 * W - 3, 8, dh, ph + 3, 1, 0, 0, BIG, -1);
      chk("hs_lock", at_speed, 1);

      // stop command with residual pulses
      run(3, 8, dh, ph, 0, 0, 1, 200, -1);
      chk("stop_slew", at_speed, 0);
      chk("stop_nofault", fault, 0);
      run(5 * W - 3, 8, dh, ph + 3, 0, 0, 1, 197, -1);
      chk("stop_halt", halted, 1);

      // alternating pulse: narrow instance must saturate
      run(W, 2, 1, 0, 0, 0, 1, BIG, -1);

      // random pulses and commands
      rh = 0; rl = 1; rs = 0;
      for (int w = 0; w < 3; w++) begin
         dens = $urandom_range(0, 30);
         for (int c = 0; c < W; c++) begin
            if ($urandom_range(0, 399) == 0) begin
               rh = 1'($urandom_range(0, 1));
               rl = 1'($urandom_range(0, 1));
               rs = 1'($urandom_range(0, 1));
            end
            rc = ($urandom_range(0, 599) == 0);
            cyc($urandom_range(0, 99) < dens, rh, rl, rs, rc);
         end
      end

      // reset mid-window
      k = $urandom_range(100, 900);
      run(k, 16, 4, 0, 0, 1, 0, BIG, -1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      fq.delete();
      cq.delete();
      #1;
      check_reset_values("midrst");
      repeat (4) @(posedge clk);
      #3;
      check_reset_values("midrst_hold");
      release_reset(1'b0, 1'b1, 1'b0);
      run(2 * W - 1, 16, 3, 0, 0, 1, 0, BIG, -1);

      // drain
      repeat (3) @(posedge clk);
      #3;
      chk("drain_flags", fq.size(), 0);
      chk("drain_counts", cq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rlim_tach.md
Name: rlim_tach

Overview:
- Speed monitor directly downstream of the rlim4 rate limiter. Consumes its o_out pulse train and the speed command that drives it (i_hs, i_ls, i_stopped).
- Measures pulse rate over a fixed window and reports when the drive is halted or locked at the commanded speed.
- Raises a sticky fault if a lock is lost while the command is unchanged.

Parameters:
- WINDOW, 1024: measurement window length in clocks.
- CW, 10: width of the edge counter and o_count.
- LOWCOUNT, 64: expected edges per window at low speed.
- HIGHCOUNT, 128: expected edges per window at high speed.
- TOL, 4: allowed deviation from the target count, inclusive.
- STOPCOUNT, 2: edge count at or below which the drive is "not moving".
- SETTLE, 3: consecutive matching windows required to change state. Must be ≥1.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset; asynchronous assert, active-high.
- i_pulse  in  1  rlim4 o_out, synchronous to i_clk.
- i_hs  in  1  high-speed command.
- i_ls  in  1  low-speed command.
- i_stopped  in  1  stop command.
- i_clr_fault  in  1  single-cycle clear for o_fault.
- o_count  out  CW  edge count of the last completed window.
- o_valid  out  1  one-cycle strobe when o_count updates.
- o_halted  out  1  state is HALT.
- o_at_speed  out  1  state is LOCK.
- o_fault  out  1  sticky loss-of-lock flag.

Behaviour:
- Reset:
  - state HALT; all counters 0.
  - o_count=0, o_valid=0, o_halted=1, o_at_speed=0, o_fault=0.
  - Reset asserted mid-window discards the partial count.
- Edge detect: pulse_q registers i_pulse. edge = i_pulse & ~pulse_q. pulse_q resets to 0, so a high input after reset counts as one edge.
- Window:
  - wcnt counts 0..WINDOW-1 and wraps.
  - ecnt increments on each edge and saturates at 2^CW-1.
  - On the cycle wcnt==WINDOW-1 (window end):
    - o_count <= ecnt + edge, saturated.
    - ecnt <= 0.
    - o_valid asserts on the next cycle for exactly one cycle.
  - First o_valid occurs WINDOW cycles after reset deassertion.
- Command target, priority i_stopped > i_hs > i_ls:
  - cmd = STOP / HIGH / LOW.
  - If none of the three is asserted, cmd = STOP.
  - cmd_q registers cmd each clock. cmd_chg = (cmd != cmd_q).
- Match, evaluated on the window-end value (ecnt+edge):
  - STOP: match = value ≤ STOPCOUNT.
  - LOW/HIGH: match = |value − target| ≤ TOL.
  - Compute the absolute difference at CW+1 bits; no wrap.
- Settle counter: on window end, match → saturating increment, otherwise clear. Any cmd_chg clears it.
- State machine (HALT, SLEW, LOCK); transitions only at window end unless noted:
  - HALT → SLEW: value > STOPCOUNT, or cmd_chg to LOW/HIGH (immediate, any cycle).
  - SLEW → LOCK: match, cmd≠STOP, and settle reaches SETTLE (i.e. settle==SETTLE-1 before the increment).
  - SLEW → HALT: same condition with cmd==STOP.
  - LOCK → SLEW on cmd_chg (immediate, settle cleared, no fault).
  - LOCK → SLEW on !match at window end with no cmd_chg in that window; also sets o_fault.
  - cmd_chg on the same cycle as window end: command change wins, no fault.
- o_halted and o_at_speed are registered decodes of state; they change the cycle after the transition.
- o_fault:
  - Set has priority over i_clr_fault on the same cycle.
  - Cleared only by i_clr_fault or reset.

Decomposition:
- Shared package rlim_pkg holds:
  - state enum {HALT, SLEW, LOCK};
  - cmd enum {CMD_STOP, CMD_LOW, CMD_HIGH};
  - the priority-decode function.
- One sub-module, rlim_tach_window: edge detect, wcnt, saturating ecnt.
  - Outputs: end strobe and window value.
  - Top level holds command tracking, match, settle and FSM.

Test Plan:
- Reset, then hold i_stopped=1 with no pulses for 4 windows:
  - o_valid every 1024 cycles, o_count=0;
  - o_halted=1 and o_at_speed=0 throughout.
- i_ls=1, pulse every 16 clocks (count 64):
  - HALT→SLEW immediately;
  - o_at_speed=1 one cycle after the 3rd consecutive window with count 64;
  - o_fault=0.
- Locked at low speed, change period to 14 clocks (count 73, outside ±4):
  - LOCK→SLEW at that window end;
  - o_fault=1 and stays 1 until an i_clr_fault pulse.
- Locked at low speed, switch to i_hs=1 with period 8 (count 128):
  - immediate SLEW, no fault;
  - relock after 3 windows with count 128.
- i_stopped=1, pulses cease:
  - first window residual count >2 keeps SLEW;
  - HALT after 3 windows with count ≤2.
- Continuous high input with one edge per cycle is impossible; instead drive an alternating pulse with CW=8:
  - o_count saturates at 255, no wrap.
- Assert reset mid-window:
  - all outputs return to reset values;
  - the next o_valid comes WINDOW cycles after release.
